sps_tx_scheduler: RTL and testbench



---
 rtl/sps_tx_scheduler_if.sv | 29 ++
 rtl/sps_tx_scheduler.sv | 110 +++++++++++
 tb/tb_sps_tx_scheduler.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sps_tx_scheduler_if.sv
// sps_tx_scheduler_if: byte requester handshakes and the PISO control bus.
// The master modport is the environment (requesters + PISO); the slave
// modport is the scheduler itself.
interface sps_tx_scheduler_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       piso_load;
    logic       piso_enable;
    logic [7:0] piso_data;
    logic       piso_char_sent;

    modport master (
        output req0_valid, req0_data, input req0_ready,
        output req1_valid, req1_data, input req1_ready,
        input  piso_load, piso_enable, piso_data,
        output piso_char_sent
    );

    modport slave (
        input  req0_valid, req0_data, output req0_ready,
        input  req1_valid, req1_data, output req1_ready,
        output piso_load, piso_enable, piso_data,
        input  piso_char_sent
    );
endinterface

// File: rtl/sps_tx_scheduler.sv
// sps_tx_scheduler: shares the SPS transmit PISO between two byte requesters.
// Each accepted byte is loaded, shifted until the PISO reports charSent (or a
// timeout aborts it), then a guard gap is enforced before the next accept.
// Optional build macro SPS_TX_FIXED_PRIO_EN: requester 0 always wins a tie
// instead of round-robin arbitration.
module sps_tx_scheduler #(
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    sps_tx_scheduler_if.slave    bus,
    output logic                 busy,
    output logic                 grant_id,
    output logic                 err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             win1;
    logic             idle;

    // Arbitration: requester 1 wins when it is alone, or on a tie it is its turn
    always_comb begin
`ifdef SPS_TX_FIXED_PRIO_EN
        win1 = bus.req1_valid & ~bus.req0_valid;
`else
        win1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
`endif
    end

    assign idle           = (state == ST_IDLE);
    assign bus.req0_ready = idle & bus.req0_valid & ~win1;
    assign bus.req1_ready = idle & win1;
    assign busy           = ~idle;

    // Scheduler FSM with registered PISO controls, grant and error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            last_grant      <= 1'b1;
            grant_id        <= 1'b0;
            err             <= 1'b0;
            bus.piso_load   <= 1'b0;
            bus.piso_enable <= 1'b0;
            bus.piso_data   <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req1_ready) begin
                        bus.piso_data <= bus.req1_data;
                        grant_id      <= 1'b1;
                        last_grant    <= 1'b1;
                        bus.piso_load <= 1'b1;
                        state         <= ST_LOAD;
                    end else if (bus.req0_ready) begin
                        bus.piso_data <= bus.req0_data;
                        grant_id      <= 1'b0;
                        last_grant    <= 1'b0;
                        bus.piso_load <= 1'b1;
                        state         <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    bus.piso_load   <= 1'b0;
                    bus.piso_enable <= 1'b1;
                    cnt             <= '0;
                    state           <= ST_SEND;
                end
                ST_SEND: begin
                    // charSent takes precedence over a coincident timeout
                    if (bus.piso_char_sent || (cnt == TO_LAST)) begin
                        err             <= ~bus.piso_char_sent;
                        bus.piso_enable <= 1'b0;
                        cnt             <= '0;
                        state           <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sps_tx_scheduler.sv
// tb_sps_tx_scheduler: directed vectors for sps_tx_scheduler with
// hand-computed expectations (GAP_CYCLES=16, TIMEOUT_CYCLES=256).
module tb_sps_tx_scheduler;

    localparam int TB_GAP = 16;
    localparam int TB_TO  = 256;

    logic clk;
    logic rst;
    logic busy;
    logic grant_id;
    logic err;

    int n_tests;
    int n_fail;

    sps_tx_scheduler_if bus ();

    sps_tx_scheduler #(
        .GAP_CYCLES    (TB_GAP),
        .TIMEOUT_CYCLES(TB_TO),
        .CNT_W         (9)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .grant_id(grant_id),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One full character: accept, load, send_cycles of SEND, then the gap
    task automatic serve(input bit k, input logic [7:0] d, input int send_cycles,
                         input bit raise1, input bit keep);
        string t;
        t = $sformatf("k%0d_%02h", k, d);
        #1;
        check({t, "_rdy0"}, bus.req0_ready, !k);
        check({t, "_rdy1"}, bus.req1_ready, k);
        step();
        if (!keep) begin
            if (k) bus.req1_valid = 1'b0;
            else   bus.req0_valid = 1'b0;
        end
        #1;
        check({t, "_load"},     bus.piso_load, 1);
        check({t, "_load_en"},  bus.piso_enable, 0);
        check({t, "_data"},     bus.piso_data, d);
        check({t, "_grant"},    grant_id, k);
        check({t, "_busy"},     busy, 1);
        check({t, "_ld_rdy0"},  bus.req0_ready, 0);
        check({t, "_ld_rdy1"},  bus.req1_ready, 0);
        step();
        check({t, "_send_ld"},  bus.piso_load, 0);
        check({t, "_send_en"},  bus.piso_enable, 1);
        if (raise1) begin
            bus.req1_valid = 1'b1;
            bus.req1_data  = 8'h5A;
        end
        repeat (send_cycles - 1) step();
        #1;
        check({t, "_send_en_last"}, bus.piso_enable, 1);
        check({t, "_send_rdy1"},    bus.req1_ready, 0);
        bus.piso_char_sent = 1'b1;
        step();
        bus.piso_char_sent = 1'b0;
        #1;
        check({t, "_gap_en"},   bus.piso_enable, 0);
        check({t, "_gap_err"},  err, 0);
        check({t, "_gap_busy"}, busy, 1);
        check({t, "_gap_rdy0"}, bus.req0_ready, 0);
        check({t, "_gap_rdy1"}, bus.req1_ready, 0);
        step();
        check({t, "_gap_err2"}, err, 0);
        repeat (TB_GAP - 2) step();
        check({t, "_gap_end_busy"}, busy, 1);
        check({t, "_gap_end_en"},   bus.piso_enable, 0);
        check({t, "_gap_end_rdy1"}, bus.req1_ready, 0);
        step();
        check({t, "_idle_busy"}, busy, 0);
    endtask

    task automatic do_reset();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        step();
        #1;
        rst = 1'b1;
    endtask

    // Watchdog: every wait below is a fixed count, this only guards a stuck sim
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        n_tests = 0;
        n_fail  = 0;
        rst                = 1'b0;
        bus.req0_valid     = 1'b0;
        bus.req0_data      = 8'h00;
        bus.req1_valid     = 1'b0;
        bus.req1_data      = 8'h00;
        bus.piso_char_sent = 1'b0;

        // Reset values
        step();
        check("rst_load",  bus.piso_load, 0);
        check("rst_en",    bus.piso_enable, 0);
        check("rst_data",  bus.piso_data, 8'h00);
        check("rst_busy0", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_err",   err, 0);
        check("rst_rdy0",  bus.req0_ready, 0);
        check("rst_rdy1",  bus.req1_ready, 0);
        #2;
        rst = 1'b1;

        // Single byte from requester 0
        step();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'hAA;
        serve(1'b0, 8'hAA, 5, 1'b0, 1'b0);

        // Requester 1 arrives mid-SEND: held off until the first IDLE cycle
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h3C;
        serve(1'b0, 8'h3C, 4, 1'b1, 1'b0);
        serve(1'b1, 8'h5A, 2, 1'b0, 1'b0);

        // Both valid from reset: 0 then 1, twice
        do_reset();
        step();
        bus.req0_valid = 1'b1; bus.req0_data = 8'h11;
        bus.req1_valid = 1'b1; bus.req1_data = 8'h22;
        serve(1'b0, 8'h11, 3, 1'b0, 1'b0);
        serve(1'b1, 8'h22, 3, 1'b0, 1'b0);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        serve(1'b0, 8'h11, 3, 1'b0, 1'b0);
        serve(1'b1, 8'h22, 3, 1'b0, 1'b0);

        // Timeout abort with a pending requester 1
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h33;
        #1;
        check("to_rdy0", bus.req0_ready, 1);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h44;
        #1;
        check("to_load", bus.piso_load, 1);
        check("to_data", bus.piso_data, 8'h33);
        step();
        check("to_send_en", bus.piso_enable, 1);
        bad = 0;
        repeat (TB_TO - 1) begin
            step();
            if (bus.piso_enable !== 1'b1 || err !== 1'b0 || bus.req1_ready !== 1'b0) bad++;
        end
        check("to_send_held", bad, 0);
        step();
        check("to_gap_en",   bus.piso_enable, 0);
        check("to_gap_err",  err, 1);
        check("to_gap_busy", busy, 1);
        step();
        check("to_err_pulse", err, 0);
        repeat (TB_GAP - 2) step();
        check("to_gap_end_busy", busy, 1);
        step();
        check("to_idle_busy", busy, 0);
        serve(1'b1, 8'h44, 3, 1'b0, 1'b0);

        // charSent on the last allowed SEND cycle: success, no err
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h55;
        serve(1'b0, 8'h55, TB_TO, 1'b0, 1'b0);

        // Both continuously valid from reset
        do_reset();
        step();
        bus.req0_valid = 1'b1; bus.req0_data = 8'h77;
        bus.req1_valid = 1'b1; bus.req1_data = 8'h88;
`ifdef SPS_TX_FIXED_PRIO_EN
        serve(1'b0, 8'h77, 2, 1'b0, 1'b1);
        serve(1'b0, 8'h77, 2, 1'b0, 1'b1);
        serve(1'b0, 8'h77, 2, 1'b0, 1'b1);
`else
        serve(1'b0, 8'h77, 2, 1'b0, 1'b1);
        serve(1'b1, 8'h88, 2, 1'b0, 1'b1);
        serve(1'b0, 8'h77, 2, 1'b0, 1'b1);
`endif
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Asynchronous reset mid-SEND, partial byte is dropped
        step();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h66;
        #1;
        check("ar_rdy0", bus.req0_ready, 1);
        step();
        bus.req0_valid = 1'b0;
        step();
        check("ar_send_en", bus.piso_enable, 1);
        #1;
        rst = 1'b0;
        #1;
        check("ar_en",    bus.piso_enable, 0);
        check("ar_busy",  busy, 0);
        check("ar_err",   err, 0);
        check("ar_load",  bus.piso_load, 0);
        check("ar_data",  bus.piso_data, 8'h00);
        check("ar_grant", grant_id, 0);
        step();
        step();
        #1;
        rst = 1'b1;
        step();
        check("ar_no_retry_busy", busy, 0);
        step();
        check("ar_no_retry_en", bus.piso_enable, 0);
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h5C;
        serve(1'b1, 8'h5C, 3, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
